avmm_resp_regmem: RTL and testbench

- Avalon-MM responder (target) that terminates one AVB channel driven by the SPI slave AVB bridge.
- Backs the channel with a small word-addressed register memory.
- Inserts programmable wait-request stalls and returns read data with a fixed latency.
- Serves as the channel endpoint in the SPI subsystem and as the reference target in the AVB-channel bench.

---
 rtl/avmm_resp_regmem.sv | 143 ++++++++++++++
 tb/tb_avmm_resp_regmem.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_resp_regmem.sv
// rtl/avmm_resp_regmem.sv - Avalon-MM responder backed by a word-addressed register memory
// Programmable waitreq stall per request, single outstanding read with fixed latency.
module avmm_resp_regmem #(
  parameter logic [16:0] ADDR_BASE   = 17'h0,
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 1,
  parameter int          RD_LATENCY  = 1,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        s_avmm_clk,
  input  logic        s_avmm_rst_n,
  input  logic [16:0] avmm_addr,
  input  logic [3:0]  avmm_byte_en,
  input  logic        avmm_write,
  input  logic        avmm_read,
  input  logic [31:0] avmm_wdata,
  output logic [31:0] avmm_rdata,
  output logic        avmm_rdatavld,
  output logic        avmm_waitreq,
  input  logic        err_clr,
  output logic        err_sticky
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_C   = 4'(WAIT_CYCLES);
  localparam logic [3:0]  LAT_LOAD = 4'(RD_LATENCY - 1);
  localparam logic [16:0] WIN_SIZE = 17'(4 * DEPTH);

  typedef enum logic [1:0] {IDLE, STALL, RDPEND} state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_wcnt, w_wcnt_nxt;
  logic [3:0]    r_lcnt, w_lcnt_nxt;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_idx;
  logic          r_rd_err;
  logic [31:0]   r_rdata;
  logic          r_err_sticky;

  logic          w_req, w_is_rd, w_accept, w_waitreq, w_rdatavld, w_err;
  logic [17:0]   w_diff;
  logic [16:0]   w_off;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rd_word;

  assign w_req   = avmm_read | avmm_write;
  assign w_is_rd = avmm_read & ~avmm_write;

  // Borrow out of the 18-bit subtraction flags addresses below the window.
  assign w_diff = {1'b0, avmm_addr} - {1'b0, ADDR_BASE};
  assign w_off  = w_diff[16:0];
  assign w_idx  = w_off[AW+1:2];
  assign w_err  = w_diff[17] | (w_off >= WIN_SIZE) | (avmm_addr[1:0] != 2'b00);

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_lcnt_nxt  = r_lcnt;
    w_waitreq   = 1'b1;
    w_accept    = 1'b0;
    w_rdatavld  = 1'b0;
    case (r_state)
      IDLE: begin
        w_waitreq = w_req & (WAIT_C != 4'd0);
        if (w_req) begin
          if (WAIT_C == 4'd0) begin
            w_accept = 1'b1;
          end else begin
            w_state_nxt = STALL;
            w_wcnt_nxt  = 4'd1;
          end
        end
      end
      STALL: begin
        w_waitreq  = (r_wcnt != WAIT_C);
        w_wcnt_nxt = r_wcnt + 4'd1;
        if (!w_req) begin
          w_state_nxt = IDLE;
        end else if (r_wcnt == WAIT_C) begin
          w_accept = 1'b1;
        end
      end
      RDPEND: begin
        w_lcnt_nxt = r_lcnt - 4'd1;
        if (r_lcnt == 4'd0) begin
          w_rdatavld  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_accept) begin
      w_state_nxt = w_is_rd ? RDPEND : IDLE;
      w_lcnt_nxt  = LAT_LOAD;
    end
  end

  // Memory is stable during RDPEND, so the response word is read in the output cycle.
  assign w_rd_word     = r_rd_err ? ERR_DATA : r_mem[r_idx];
  assign avmm_waitreq  = ~s_avmm_rst_n | w_waitreq;
  assign avmm_rdatavld = s_avmm_rst_n & w_rdatavld;
  assign avmm_rdata    = avmm_rdatavld ? w_rd_word : r_rdata;
  assign err_sticky    = r_err_sticky;

  always_ff @(posedge s_avmm_clk) begin
    if (!s_avmm_rst_n) begin
      r_state      <= IDLE;
      r_wcnt       <= 4'd0;
      r_lcnt       <= 4'd0;
      r_idx        <= '0;
      r_rd_err     <= 1'b0;
      r_rdata      <= 32'd0;
      r_err_sticky <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_lcnt  <= w_lcnt_nxt;
      if (avmm_rdatavld) begin
        r_rdata <= w_rd_word;
      end
      if (w_accept && w_is_rd) begin
        r_idx    <= w_idx;
        r_rd_err <= w_err;
      end
      if (w_accept && avmm_write && !w_err) begin
        for (int b = 0; b < 4; b++) begin
          if (avmm_byte_en[b]) begin
            r_mem[w_idx][8*b +: 8] <= avmm_wdata[8*b +: 8];
          end
        end
      end
      if (w_accept && (w_err || (avmm_read && avmm_write))) begin
        r_err_sticky <= 1'b1;
      end else if (err_clr) begin
        r_err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_avmm_resp_regmem.sv
// tb/tb_avmm_resp_regmem.sv - scoreboard bench for avmm_resp_regmem
// Three parameterisations share one stimulus bus; sel picks the instance being observed.
module tb_avmm_resp_regmem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [16:0] addr = '0;
  logic [3:0]  be = '0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] wdata = '0;
  logic        err_clr = 1'b0;
  logic [1:0]  sel = 2'd0;

  logic [31:0] rd_v [3];
  logic        rv_v [3];
  logic        wq_v [3];
  logic        es_v [3];
  logic [31:0] rd_s;
  logic        rv_s, wq_s, es_s;

  int lat_p [3] = '{1, 4, 2};
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avmm_resp_regmem #(.ADDR_BASE(17'h0), .DEPTH(64), .WAIT_CYCLES(1), .RD_LATENCY(1),
                     .ERR_DATA(32'hDEAD_BEEF)) u_dut0 (
    .s_avmm_clk(clk), .s_avmm_rst_n(rst_n), .avmm_addr(addr), .avmm_byte_en(be),
    .avmm_write(wr), .avmm_read(rd), .avmm_wdata(wdata), .avmm_rdata(rd_v[0]),
    .avmm_rdatavld(rv_v[0]), .avmm_waitreq(wq_v[0]), .err_clr(err_clr), .err_sticky(es_v[0]));

  avmm_resp_regmem #(.ADDR_BASE(17'h100), .DEPTH(16), .WAIT_CYCLES(3), .RD_LATENCY(4),
                     .ERR_DATA(32'hDEAD_BEEF)) u_dut1 (
    .s_avmm_clk(clk), .s_avmm_rst_n(rst_n), .avmm_addr(addr), .avmm_byte_en(be),
    .avmm_write(wr), .avmm_read(rd), .avmm_wdata(wdata), .avmm_rdata(rd_v[1]),
    .avmm_rdatavld(rv_v[1]), .avmm_waitreq(wq_v[1]), .err_clr(err_clr), .err_sticky(es_v[1]));

  avmm_resp_regmem #(.ADDR_BASE(17'h0), .DEPTH(64), .WAIT_CYCLES(0), .RD_LATENCY(2),
                     .ERR_DATA(32'hDEAD_BEEF)) u_dut2 (
    .s_avmm_clk(clk), .s_avmm_rst_n(rst_n), .avmm_addr(addr), .avmm_byte_en(be),
    .avmm_write(wr), .avmm_read(rd), .avmm_wdata(wdata), .avmm_rdata(rd_v[2]),
    .avmm_rdatavld(rv_v[2]), .avmm_waitreq(wq_v[2]), .err_clr(err_clr), .err_sticky(es_v[2]));

  always_comb begin
    rd_s = rd_v[0];
    rv_s = rv_v[0];
    wq_s = wq_v[0];
    es_s = es_v[0];
    case (sel)
      2'd1: begin rd_s = rd_v[1]; rv_s = rv_v[1]; wq_s = wq_v[1]; es_s = es_v[1]; end
      2'd2: begin rd_s = rd_v[2]; rv_s = rv_v[2]; wq_s = wq_v[2]; es_s = es_v[2]; end
      default: ;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (dut%0d, cycle %0d)", nm, act, exp, sel, cyc);
    end
  endtask

  // Response monitor: every rdatavld pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rv_s) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rdatavld_unexpected: got pulse with rdata 0x%08h expected none (dut%0d, cycle %0d)",
                 rd_s, sel, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("rdata", rd_s, mon_e.data);
        chk("rdatavld_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Starts at a posedge+1 and returns at posedge+1 just after the acceptance edge.
  task automatic access(input bit w, input bit r, input logic [16:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [31:0] exp, input bit push,
                        output int stalls);
    bit done = 1'b0;
    stalls = 0;
    wr = w; rd = r; addr = a; wdata = d; be = b;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      if (wq_s) begin
        stalls++;
      end else begin
        done = 1'b1;
        if (r && !w && push) sb.push_back('{exp, cyc + lat_p[sel]});
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got no acceptance for addr 0x%05h expected one within 64 cycles", a);
    end
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("waitreq_in_reset", wq_s, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] burst_d [8] = '{32'h0000_0001, 32'h1111_1112, 32'h2222_2224, 32'h3333_3338,
                               32'h4444_4440, 32'h5555_5550, 32'h6666_6660, 32'h7777_7770};

  initial begin
    int st, tot, cnt;

    // Defaults: reset state, basic write/read, byte enables, read+write collision.
    sel = 2'd0;
    reset_all();
    @(negedge clk);
    chk("reset_rdata", rd_s, 0);
    chk("reset_rdatavld", rv_s, 0);
    chk("reset_err", es_s, 0);
    chk("idle_waitreq", wq_s, 0);
    @(posedge clk); #1;

    access(1, 0, 17'h0C, 32'h1234_5678, 4'hF, 0, 1, st);
    chk("basic_wr_stall", st, 1);
    access(0, 1, 17'h0C, 0, 4'hF, 32'h1234_5678, 1, st);
    chk("basic_rd_stall", st, 1);
    @(negedge clk);
    @(negedge clk);
    chk("rdata_hold", rd_s, 32'h1234_5678);
    chk("rdatavld_low", rv_s, 0);
    chk("basic_err", es_s, 0);
    @(posedge clk); #1;

    access(1, 0, 17'h08, 32'hAABB_CCDD, 4'hF, 0, 1, st);
    access(1, 0, 17'h08, 32'h1122_3344, 4'b0101, 0, 1, st);
    access(0, 1, 17'h08, 0, 4'h0, 32'hAA22_CC44, 1, st);
    idle_cycles(2);

    access(1, 1, 17'h10, 32'h5A5A_0F0F, 4'hF, 0, 1, st);
    chk("rdwr_both_err", es_s, 1);
    access(0, 1, 17'h10, 0, 4'hF, 32'h5A5A_0F0F, 1, st);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_clr", es_s, 0);
    idle_cycles(2);

    // WAIT_CYCLES=3, RD_LATENCY=4, window 0x100..0x13F.
    sel = 2'd1;
    reset_all();
    access(1, 0, 17'h100, 32'h0BAD_F00D, 4'hF, 0, 1, st);
    chk("w3_wr_stall", st, 3);
    access(1, 0, 17'h13C, 32'hCAFE_0001, 4'hF, 0, 1, st);
    access(0, 1, 17'h100, 0, 4'hF, 32'h0BAD_F00D, 1, st);
    chk("w3_rd_stall", st, 3);
    access(1, 0, 17'h104, 32'h0000_1234, 4'hF, 0, 1, st);
    chk("wr_behind_rdpend_stall", st, 7);
    chk("in_window_err", es_s, 0);

    access(1, 0, 17'h0FC, 32'hFFFF_FFFF, 4'hF, 0, 1, st);
    access(1, 0, 17'h140, 32'hEEEE_EEEE, 4'hF, 0, 1, st);
    access(0, 1, 17'h102, 0, 4'hF, 32'hDEAD_BEEF, 1, st);
    chk("window_err", es_s, 1);
    access(0, 1, 17'h100, 0, 4'hF, 32'h0BAD_F00D, 1, st);
    access(0, 1, 17'h13C, 0, 4'hF, 32'hCAFE_0001, 1, st);
    access(0, 1, 17'h104, 0, 4'hF, 32'h0000_1234, 1, st);
    idle_cycles(6);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("w3_err_clr", es_s, 0);
    err_clr = 1'b1;
    access(1, 0, 17'h200, 32'h0, 4'hF, 0, 1, st);
    chk("err_set_wins", es_s, 1);
    err_clr = 1'b0;

    access(1, 0, 17'h108, 32'h5555_AAAA, 4'hF, 0, 1, st);
    access(0, 1, 17'h108, 0, 4'hF, 0, 0, st);
    rst_n = 1'b0;
    @(negedge clk);
    chk("waitreq_mid_reset", wq_s, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rv_s) cnt++;
    end
    chk("dropped_read_pulses", cnt, 0);
    chk("post_reset_err", es_s, 0);
    @(posedge clk); #1;
    access(0, 1, 17'h108, 0, 4'hF, 32'h0, 1, st);
    access(0, 1, 17'h100, 0, 4'hF, 32'h0, 1, st);
    idle_cycles(6);

    // WAIT_CYCLES=0, RD_LATENCY=2: back-to-back burst.
    sel = 2'd2;
    reset_all();
    tot = 0;
    for (int k = 0; k < 8; k++) begin
      access(1, 0, 17'(4 * k), burst_d[k], 4'hF, 0, 1, st);
      tot += st;
    end
    chk("burst_wr_stalls", tot, 0);
    tot = 0;
    for (int k = 0; k < 8; k++) begin
      access(0, 1, 17'(4 * k), 0, 4'hF, burst_d[k], 1, st);
      tot += st;
    end
    chk("burst_rd_stalls", tot, 14);

    cnt = 0;
    while (sb.size() != 0 && cnt < 32) begin
      @(posedge clk);
      cnt++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d responses outstanding expected 0", sb.size());
    end
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
